ber_checker_win: RTL

- Parametrised successor of the 132-bit error-flag checker.
- Compares a received word against a reference word on every valid beat and registers the per-bit error flags.
- Counts bit errors, errored words and samples over a programmable measurement window, with a start/abort/done control FSM.
- Sits at the end of the BER simulation chain, after the link and reference generator; feeds the testbench/report logic.

---
 rtl/ber_pkg.sv | 30 +++
 rtl/ber_popcount.sv | 20 ++
 rtl/ber_checker_win.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ber_pkg.sv
// Shared types and helpers for the windowed bit-error-rate checker.
package ber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Bits needed to represent v distinct values (at least 1).
    function automatic int clog2(input int unsigned v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Unsigned add clamped to the all-ones value of a w-bit counter (w <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] s;
        logic [64:0] mx;
        s  = {1'b0, a} + {1'b0, b};
        mx = (65'd1 << w) - 65'd1;
        return (s > mx) ? mx[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/ber_popcount.sv
// Combinational population count of a WIDTH-bit word.
module ber_popcount
    import ber_pkg::*;
#(
    parameter int WIDTH = 132
) (
    input  logic [WIDTH-1:0]            data,
    output logic [clog2(WIDTH+1)-1:0]   count
);

    localparam int PW = clog2(WIDTH + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + PW'(data[i]);
        end
    end

endmodule

// File: rtl/ber_checker_win.sv
// Windowed BER checker: per-beat error flags plus saturating bit/word/sample counters.
// Optional per-lane error counters are enabled with `define BER_CHECKER_LANE_CNT_EN.
module ber_checker_win
    import ber_pkg::*;
#(
    parameter int WIDTH      = 132,
    parameter int CNT_W      = 40,
    parameter int WIN_W      = 32,
    parameter int LANE_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [WIN_W-1:0]          win_len,
    input  logic                      valid_in,
    input  logic [WIDTH-1:0]          bit_rec,
    input  logic [WIDTH-1:0]          bit_ref,
`ifdef BER_CHECKER_LANE_CNT_EN
    input  logic [clog2(WIDTH)-1:0]   lane_sel,
    output logic [LANE_CNT_W-1:0]     lane_err_cnt,
`endif
    output logic [WIDTH-1:0]          flag,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          bit_err_cnt,
    output logic [CNT_W-1:0]          word_err_cnt,
    output logic [CNT_W-1:0]          sample_cnt
);

    localparam int PC_W = clog2(WIDTH + 1);

    state_t            state, state_nx;
    logic              clr, cnt_en;
    logic [WIN_W-1:0]  win_reg;
    logic [WIDTH-1:0]  diff;
    logic [PC_W-1:0]   pc;
    logic [CNT_W-1:0]  bit_sum, word_sum, sample_sum;
    logic              win_hit;

    assign diff = bit_rec ^ bit_ref;

    ber_popcount #(.WIDTH(WIDTH)) u_pop (
        .data  (diff),
        .count (pc)
    );

    assign bit_sum    = CNT_W'(sat_add(64'(bit_err_cnt),  64'(pc),    CNT_W));
    assign word_sum   = CNT_W'(sat_add(64'(word_err_cnt), 64'(|diff), CNT_W));
    assign sample_sum = CNT_W'(sat_add(64'(sample_cnt),   64'd1,      CNT_W));
    // A zero window length means free-run until abort.
    assign win_hit    = (win_reg != '0) && (sample_sum == CNT_W'(win_reg));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        cnt_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clr      = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nx = ST_DONE;
                end else if (start) begin
                    clr = 1'b1;
                end else if (valid_in) begin
                    cnt_en = 1'b1;
                    if (win_hit) state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (start) begin
                    clr      = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            flag         <= '0;
            bit_err_cnt  <= '0;
            word_err_cnt <= '0;
            sample_cnt   <= '0;
        end else if (cnt_en) begin
            flag         <= diff;
            bit_err_cnt  <= bit_sum;
            word_err_cnt <= word_sum;
            sample_cnt   <= sample_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)      win_reg <= '0;
        else if (clr) win_reg <= win_len;
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

`ifdef BER_CHECKER_LANE_CNT_EN
    logic [LANE_CNT_W-1:0] lane_cnt [WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (rst || clr)
                lane_cnt[i] <= '0;
            else if (cnt_en && diff[i] && (lane_cnt[i] != '1))
                lane_cnt[i] <= lane_cnt[i] + 1'b1;
        end
    end

    assign lane_err_cnt = (32'(lane_sel) < WIDTH) ? lane_cnt[lane_sel] : '0;
`endif

endmodule
